// File: rtl/mips_muldiv_seq_pkg.sv
// Shared constants and types for the HI/LO multiply/divide sequencer.
package mips_muldiv_seq_pkg;

   localparam int unsigned MD_DATA_W = 32;

   // Opcode of the R-type (SPECIAL) group; funct selects the operation.
   localparam logic [5:0] OP_SPECIAL = 6'h00;

   // funct values of the HI/LO instruction group.
   localparam logic [5:0] OP0_MFHI  = 6'h10;
   localparam logic [5:0] OP0_MTHI  = 6'h11;
   localparam logic [5:0] OP0_MFLO  = 6'h12;
   localparam logic [5:0] OP0_MTLO  = 6'h13;
   localparam logic [5:0] OP0_MULT  = 6'h18;
   localparam logic [5:0] OP0_MULTU = 6'h19;
   localparam logic [5:0] OP0_DIV   = 6'h1A;
   localparam logic [5:0] OP0_DIVU  = 6'h1B;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_RUN  = 2'd1,
      MD_FIX  = 2'd2
   } md_state_t;

endpackage

// File: rtl/mips_muldiv_dp.sv
// One shift-add / restoring-divide iteration plus the sign-fixup negators.
module mips_muldiv_dp #(
   parameter int unsigned DATA_W = 32
) (
   input  logic              is_div,
   input  logic              neg_q,
   input  logic              neg_r,
   input  logic [DATA_W-1:0] acc_hi,
   input  logic [DATA_W-1:0] acc_lo,
   input  logic [DATA_W-1:0] opnd,
   output logic [DATA_W-1:0] step_hi_c,
   output logic [DATA_W-1:0] step_lo_c,
   output logic [DATA_W-1:0] fix_hi_c,
   output logic [DATA_W-1:0] fix_lo_c
);

   localparam int unsigned W2 = 2 * DATA_W;

   logic [DATA_W:0]   add_sum;
   logic [DATA_W+1:0] trial;
   logic [W2-1:0]     prod_neg;

   // Single iteration: acc_hi is the running product high / remainder,
   // acc_lo the multiplier being shifted out / dividend becoming quotient.
   always_comb begin
      add_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
      trial     = {1'b0, acc_hi, acc_lo[DATA_W-1]} - {2'b00, opnd};
      step_hi_c = add_sum[DATA_W:1];
      step_lo_c = {add_sum[0], acc_lo[DATA_W-1:1]};
      if (is_div) begin
         if (!trial[DATA_W+1]) begin
            step_hi_c = trial[DATA_W-1:0];
            step_lo_c = {acc_lo[DATA_W-2:0], 1'b1};
         end else begin
            step_hi_c = {acc_hi[DATA_W-2:0], acc_lo[DATA_W-1]};
            step_lo_c = {acc_lo[DATA_W-2:0], 1'b0};
         end
      end
   end

   // Sign fixup: whole product negated for mul; quotient and remainder
   // negated independently for div.
   always_comb begin
      prod_neg = (~{acc_hi, acc_lo}) + W2'(1);
      fix_hi_c = acc_hi;
      fix_lo_c = acc_lo;
      if (is_div) begin
         if (neg_q) fix_lo_c = (~acc_lo) + DATA_W'(1);
         if (neg_r) fix_hi_c = (~acc_hi) + DATA_W'(1);
      end else if (neg_q) begin
         fix_hi_c = prod_neg[W2-1:DATA_W];
         fix_lo_c = prod_neg[DATA_W-1:0];
      end
   end

endmodule

// File: rtl/mips_muldiv_seq.sv
// HI/LO owner and sequencer for MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO.
module mips_muldiv_seq
   import mips_muldiv_seq_pkg::*;
#(
   parameter int unsigned DATA_W = MD_DATA_W,
   parameter int unsigned CNT_W  = $clog2(DATA_W)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inst_valid,
   input  logic [5:0]        op,
   input  logic [5:0]        funct,
   input  logic [DATA_W-1:0] rs_data,
   input  logic [DATA_W-1:0] rt_data,
   output logic              stall,
   output logic              busy,
   output logic [DATA_W-1:0] hilo_rdata,
   output logic              hilo_rd_we,
   output logic [DATA_W-1:0] hi_q,
   output logic [DATA_W-1:0] lo_q
);

   md_state_t         state_q, state_d;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] acc_hi, acc_lo, opnd, dvd_raw;
   logic              md_div, md_neg_q, md_neg_r, md_dz;

   logic              hl_inst, f_div, f_sgn;
   logic [DATA_W-1:0] rs_abs, rt_abs;
   logic              load_en, step_en, fix_en, mthi_en, mtlo_en;
   logic [DATA_W-1:0] step_hi, step_lo, fix_hi, fix_lo;

   // Instruction decode and operand magnitudes for the signed forms.
   always_comb begin
      hl_inst = inst_valid && (op == OP_SPECIAL) &&
                ((funct == OP0_MFHI) || (funct == OP0_MTHI) ||
                 (funct == OP0_MFLO) || (funct == OP0_MTLO) ||
                 (funct == OP0_MULT) || (funct == OP0_MULTU) ||
                 (funct == OP0_DIV)  || (funct == OP0_DIVU));
      f_div  = (funct == OP0_DIV)  || (funct == OP0_DIVU);
      f_sgn  = (funct == OP0_MULT) || (funct == OP0_DIV);
      rs_abs = (f_sgn && rs_data[DATA_W-1]) ? (~rs_data) + DATA_W'(1) : rs_data;
      rt_abs = (f_sgn && rt_data[DATA_W-1]) ? (~rt_data) + DATA_W'(1) : rt_data;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= MD_IDLE;
      else     state_q <= state_d;
   end

   // Next state, stall and MFHI/MFLO read port; HI/LO work happens only in IDLE.
   always_comb begin
      state_d    = state_q;
      stall      = 1'b0;
      busy       = (state_q != MD_IDLE);
      hilo_rd_we = 1'b0;
      hilo_rdata = '0;
      load_en    = 1'b0;
      step_en    = 1'b0;
      fix_en     = 1'b0;
      mthi_en    = 1'b0;
      mtlo_en    = 1'b0;
      unique case (state_q)
         MD_IDLE: begin
            if (hl_inst) begin
               unique case (funct)
                  OP0_MULT, OP0_MULTU, OP0_DIV, OP0_DIVU: begin
                     load_en = 1'b1;
                     state_d = MD_RUN;
                  end
                  OP0_MFHI: begin
                     hilo_rd_we = 1'b1;
                     hilo_rdata = hi_q;
                  end
                  OP0_MFLO: begin
                     hilo_rd_we = 1'b1;
                     hilo_rdata = lo_q;
                  end
                  OP0_MTHI: mthi_en = 1'b1;
                  OP0_MTLO: mtlo_en = 1'b1;
                  default: ;
               endcase
            end
         end
         MD_RUN: begin
            stall   = hl_inst;
            step_en = 1'b1;
            if (cnt == CNT_W'(DATA_W - 1)) state_d = MD_FIX;
         end
         MD_FIX: begin
            stall   = hl_inst;
            fix_en  = 1'b1;
            state_d = MD_IDLE;
         end
         default: state_d = MD_IDLE;
      endcase
   end

   mips_muldiv_dp #(.DATA_W(DATA_W)) u_dp (
      .is_div    (md_div),
      .neg_q     (md_neg_q),
      .neg_r     (md_neg_r),
      .acc_hi    (acc_hi),
      .acc_lo    (acc_lo),
      .opnd      (opnd),
      .step_hi_c (step_hi),
      .step_lo_c (step_lo),
      .fix_hi_c  (fix_hi),
      .fix_lo_c  (fix_lo)
   );

   // Operand latch, iteration accumulator and counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         acc_hi   <= '0;
         acc_lo   <= '0;
         opnd     <= '0;
         dvd_raw  <= '0;
         md_div   <= 1'b0;
         md_neg_q <= 1'b0;
         md_neg_r <= 1'b0;
         md_dz    <= 1'b0;
      end else if (load_en) begin
         cnt      <= '0;
         acc_hi   <= '0;
         acc_lo   <= f_div ? rs_abs : rt_abs;
         opnd     <= f_div ? rt_abs : rs_abs;
         dvd_raw  <= rs_data;
         md_div   <= f_div;
         md_neg_q <= f_sgn && (rs_data[DATA_W-1] ^ rt_data[DATA_W-1]);
         md_neg_r <= f_sgn && rs_data[DATA_W-1];
         md_dz    <= f_div && (rt_data == '0);
      end else if (step_en) begin
         cnt    <= cnt + CNT_W'(1);
         acc_hi <= step_hi;
         acc_lo <= step_lo;
      end
   end

   // Architectural HI/LO: MTHI/MTLO in IDLE, result on the fixup cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         hi_q <= '0;
         lo_q <= '0;
      end else if (fix_en) begin
         if (md_div && md_dz) begin
            hi_q <= dvd_raw;
            lo_q <= '1;
         end else begin
            hi_q <= fix_hi;
            lo_q <= fix_lo;
         end
      end else begin
         if (mthi_en) hi_q <= rs_data;
         if (mtlo_en) lo_q <= rs_data;
      end
   end

endmodule
